// File: rtl/soc_pkg.sv
// Shared MDIO management definitions: FSM encoding, opcodes and preamble length.
package soc_pkg;

  typedef logic [2:0] mdio_state_e;

  localparam mdio_state_e MDIO_PRE   = 3'd0;
  localparam mdio_state_e MDIO_ST    = 3'd1;
  localparam mdio_state_e MDIO_OP    = 3'd2;
  localparam mdio_state_e MDIO_PHYAD = 3'd3;
  localparam mdio_state_e MDIO_REGAD = 3'd4;
  localparam mdio_state_e MDIO_TA    = 3'd5;
  localparam mdio_state_e MDIO_DATA  = 3'd6;

  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  localparam int unsigned MDIO_PRE_LEN = 32;

  // Status register image with the live link bit spliced into bit 2.
  function automatic logic [15:0] mdio_bmsr(input logic [15:0] base, input logic link);
    logic [15:0] v;
    v    = base;
    v[2] = link;
    return v;
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer with a rising-edge detector on the synchronized output.
module mdio_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= {3{ResetVal}};
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  assign q_o    = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO, decodes frames for the strapped
// PHY address and serves a 32x16 register file.
module mdio_responder
  import soc_pkg::*;
#(
  parameter logic [15:0] PHY_ID1   = 16'h0000,
  parameter logic [15:0] PHY_ID2   = 16'h0000,
  parameter logic [15:0] BMSR_BASE = 16'h7849
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  phy_addr,
  input  logic        link_up,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        sw_reset
);

  localparam logic [5:0] PreLen = 6'(MDIO_PRE_LEN);

  logic mdc_s, mdc_rise, mdio_s, mdio_rise_unused;

  mdio_sync_edge #(.ResetVal(1'b0)) u_sync_mdc (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mdc),
    .q_o    (mdc_s),
    .rise_o (mdc_rise)
  );

  mdio_sync_edge #(.ResetVal(1'b1)) u_sync_mdio (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mdio_i),
    .q_o    (mdio_s),
    .rise_o (mdio_rise_unused)
  );

  mdio_state_e state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  addr_sh_q, addr_sh_d;
  logic [4:0]  regad_q, regad_d;
  logic        match_q, match_d;
  logic [15:0] sh_q, sh_d;
  logic        mdio_o_q, mdio_o_d, mdio_oe_q, mdio_oe_d;
  logic        wr_en_q, wr_en_d, sw_reset_q, sw_reset_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        commit;
  logic [15:0] regs_q [32];
  logic [4:0]  rd_addr;
  logic [15:0] rd_val;
  logic        rd_match;

  assign rd_addr  = {addr_sh_q[3:0], mdio_s};
  assign rd_match = (op_q == MDIO_OP_RD) && match_q;

  always_comb begin
    unique case (rd_addr)
      5'd1:    rd_val = mdio_bmsr(BMSR_BASE, link_up);
      5'd2:    rd_val = PHY_ID1;
      5'd3:    rd_val = PHY_ID2;
      default: rd_val = regs_q[rd_addr];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_d       = op_q;
    addr_sh_d  = addr_sh_q;
    regad_d    = regad_q;
    match_d    = match_q;
    sh_d       = sh_q;
    mdio_o_d   = mdio_o_q;
    mdio_oe_d  = mdio_oe_q;
    wr_en_d    = 1'b0;
    sw_reset_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    commit     = 1'b0;
    if (mdc_rise) begin
      case (state_q)
        MDIO_PRE: begin
          if (mdio_s) begin
            if (pre_cnt_q != PreLen) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (pre_cnt_q == PreLen) begin
            state_d   = MDIO_ST;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        MDIO_ST: begin
          if (mdio_s) begin
            state_d   = MDIO_OP;
            bit_cnt_d = '0;
          end else begin
            state_d   = MDIO_PRE;
            pre_cnt_d = '0;
          end
        end
        MDIO_OP: begin
          op_d = {op_q[0], mdio_s};
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else if (op_d == MDIO_OP_RD || op_d == MDIO_OP_WR) begin
            state_d   = MDIO_PHYAD;
            bit_cnt_d = '0;
          end else begin
            state_d   = MDIO_PRE;
            pre_cnt_d = '0;
          end
        end
        MDIO_PHYAD: begin
          addr_sh_d = rd_addr;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            match_d   = (rd_addr == phy_addr);
            state_d   = MDIO_REGAD;
            bit_cnt_d = '0;
          end
        end
        MDIO_REGAD: begin
          addr_sh_d = rd_addr;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            regad_d   = rd_addr;
            sh_d      = rd_val;
            state_d   = MDIO_TA;
            bit_cnt_d = '0;
          end
        end
        MDIO_TA: begin
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
            if (rd_match) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end
          end else if (op_q == MDIO_OP_WR && mdio_s) begin
            state_d   = MDIO_PRE;
            pre_cnt_d = '0;
          end else begin
            state_d   = MDIO_DATA;
            bit_cnt_d = '0;
            if (rd_match) begin
              mdio_o_d = sh_q[15];
              sh_d     = {sh_q[14:0], 1'b0};
            end
          end
        end
        MDIO_DATA: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (op_q == MDIO_OP_RD) begin
            if (bit_cnt_q != 5'd15) begin
              if (match_q) mdio_o_d = sh_q[15];
              sh_d = {sh_q[14:0], 1'b0};
            end else begin
              // Initiator has just sampled D0; release the pad.
              mdio_oe_d = 1'b0;
              mdio_o_d  = 1'b1;
              state_d   = MDIO_PRE;
              pre_cnt_d = '0;
            end
          end else begin
            sh_d = {sh_q[14:0], mdio_s};
            if (bit_cnt_q == 5'd15) begin
              if (match_q) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = regad_q;
                wr_data_d  = sh_d;
                sw_reset_d = (regad_q == 5'd0) && sh_d[15];
                commit     = 1'b1;
              end
              state_d   = MDIO_PRE;
              pre_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d   = MDIO_PRE;
          pre_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MDIO_PRE;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      op_q       <= '0;
      addr_sh_q  <= '0;
      regad_q    <= '0;
      match_q    <= 1'b0;
      sh_q       <= '0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      sw_reset_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_q       <= op_d;
      addr_sh_q  <= addr_sh_d;
      regad_q    <= regad_d;
      match_q    <= match_d;
      sh_q       <= sh_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
      wr_en_q    <= wr_en_d;
      sw_reset_q <= sw_reset_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Regs 1-3 are constants; reg 0 bit 15 is a self-clearing reset request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (commit && !(regad_q inside {5'd1, 5'd2, 5'd3})) begin
      regs_q[regad_q] <= (regad_q == 5'd0) ? {1'b0, sh_d[14:0]} : sh_d;
    end
  end

  assign mdio_o   = mdio_o_q;
  assign mdio_oe  = mdio_oe_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign sw_reset = sw_reset_q;

  logic unused_mdc_s;
  assign unused_mdc_s = mdc_s;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: table of read/write frames plus abort and reset cases.
module tb_mdio_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  phy_addr = 5'd1;
  logic        link_up = 1'b0;
  logic        mdc = 1'b0;
  logic        drv = 1'b1;
  logic        mdio_o, mdio_oe, wr_en, sw_reset;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  wire         pad = mdio_oe ? mdio_o : drv;

  mdio_responder #(
    .PHY_ID1   (16'h0022),
    .PHY_ID2   (16'h0141),
    .BMSR_BASE (16'h7849)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .phy_addr (phy_addr),
    .link_up  (link_up),
    .mdc      (mdc),
    .mdio_i   (pad),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sw_reset (sw_reset)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int oe_cyc = 0, wr_cyc = 0, sw_cyc = 0;
  logic [4:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  always @(negedge clk) begin
    if (mdio_oe) oe_cyc++;
    if (wr_en) begin
      wr_cyc++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (sw_reset) sw_cyc++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Drive on the falling half, sample the pad just before the rising edge.
  task automatic mdc_bit(input logic b, output logic s);
    drv = b;
    #HALF;
    s = pad;
    mdc = 1'b1;
    #HALF;
    mdc = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) mdc_bit(v[i], s);
  endtask

  task automatic send_hdr(input logic rd, input logic [4:0] pa, input logic [4:0] ra);
    send_bits(32'hFFFF_FFFF, 32);
    send_bits({28'd0, 2'b01, rd ? 2'b10 : 2'b01}, 4);
    send_bits({27'd0, pa}, 5);
    send_bits({27'd0, ra}, 5);
  endtask

  task automatic do_frame(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input logic ta2,
                          output logic [15:0] rdata, output logic ta2_s);
    logic s;
    rdata = '0;
    send_hdr(rd, pa, ra);
    if (rd) begin
      mdc_bit(1'b1, s);
      mdc_bit(1'b1, ta2_s);
      for (int i = 0; i < 16; i++) begin
        mdc_bit(1'b1, s);
        rdata = {rdata[14:0], s};
      end
    end else begin
      mdc_bit(1'b1, s);
      mdc_bit(ta2, ta2_s);
      send_bits({16'd0, wd}, 16);
    end
    drv = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic        ta2;
    logic [15:0] exp_rd;
    int          exp_wr;
    int          exp_sw;
    logic        exp_drive;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [15:0] rdata;
    logic        ta2s, s;
    int          w0, s0, o0;

    vecs[0]  = '{1'b1, 5'd1, 5'd2,  16'h0000, 1'b0, 16'h0022, 0, 0, 1'b1};
    vecs[1]  = '{1'b1, 5'd1, 5'd3,  16'h0000, 1'b0, 16'h0141, 0, 0, 1'b1};
    vecs[2]  = '{1'b1, 5'd1, 5'd1,  16'h0000, 1'b0, 16'h7849, 0, 0, 1'b1};
    vecs[3]  = '{1'b0, 5'd1, 5'd4,  16'hABCD, 1'b0, 16'h0000, 1, 0, 1'b0};
    vecs[4]  = '{1'b1, 5'd1, 5'd4,  16'h0000, 1'b0, 16'hABCD, 0, 0, 1'b1};
    vecs[5]  = '{1'b0, 5'd1, 5'd0,  16'h8140, 1'b0, 16'h0000, 1, 1, 1'b0};
    vecs[6]  = '{1'b1, 5'd1, 5'd0,  16'h0000, 1'b0, 16'h0140, 0, 0, 1'b1};
    vecs[7]  = '{1'b0, 5'd1, 5'd1,  16'hFFFF, 1'b0, 16'h0000, 1, 0, 1'b0};
    vecs[8]  = '{1'b1, 5'd1, 5'd1,  16'h0000, 1'b0, 16'h7849, 0, 0, 1'b1};
    vecs[9]  = '{1'b1, 5'd7, 5'd4,  16'h0000, 1'b0, 16'hFFFF, 0, 0, 1'b0};
    vecs[10] = '{1'b0, 5'd7, 5'd5,  16'h1234, 1'b0, 16'h0000, 0, 0, 1'b0};
    vecs[11] = '{1'b1, 5'd1, 5'd5,  16'h0000, 1'b0, 16'h0000, 0, 0, 1'b1};
    vecs[12] = '{1'b0, 5'd1, 5'd31, 16'h5A5A, 1'b0, 16'h0000, 1, 0, 1'b0};
    vecs[13] = '{1'b1, 5'd1, 5'd31, 16'h0000, 1'b0, 16'h5A5A, 0, 0, 1'b1};
    vecs[14] = '{1'b0, 5'd1, 5'd4,  16'h0000, 1'b1, 16'h0000, 0, 0, 1'b0};
    vecs[15] = '{1'b1, 5'd1, 5'd4,  16'h0000, 1'b0, 16'hABCD, 0, 0, 1'b1};

    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst mdio_oe", 32'(mdio_oe), 32'd0);
    chk("rst mdio_o", 32'(mdio_o), 32'd1);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    chk("rst sw_reset", 32'(sw_reset), 32'd0);

    for (int i = 0; i < 16; i++) begin
      w0 = wr_cyc; s0 = sw_cyc; o0 = oe_cyc;
      do_frame(vecs[i].rd, vecs[i].pa, vecs[i].ra, vecs[i].wd, vecs[i].ta2, rdata, ta2s);
      chk($sformatf("v%0d wr_en cycles", i), 32'(wr_cyc - w0), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d sw_reset cycles", i), 32'(sw_cyc - s0), 32'(vecs[i].exp_sw));
      chk($sformatf("v%0d oe released", i), 32'(mdio_oe), 32'd0);
      if (vecs[i].exp_wr != 0) begin
        chk($sformatf("v%0d wr_addr", i), 32'(last_addr), 32'(vecs[i].ra));
        chk($sformatf("v%0d wr_data", i), 32'(last_data), 32'(vecs[i].wd));
      end
      if (vecs[i].rd) begin
        chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].exp_rd));
        chk($sformatf("v%0d drove", i), 32'(oe_cyc != o0), 32'(vecs[i].exp_drive));
        if (vecs[i].exp_drive) chk($sformatf("v%0d ta2 bit", i), 32'(ta2s), 32'd0);
      end
    end

    // 31-bit preamble: frame must be ignored.
    o0 = oe_cyc;
    send_bits(32'h7FFF_FFFF, 31);
    send_bits({28'd0, 4'b0110}, 4);
    send_bits({22'd0, 5'd1, 5'd2}, 10);
    send_bits(32'h0003_FFFF, 18);
    repeat (10) @(posedge clk);
    chk("short preamble no drive", 32'(oe_cyc - o0), 32'd0);

    // OP=11 aborts; following valid frame must decode.
    o0 = oe_cyc; w0 = wr_cyc;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits({28'd0, 4'b0111}, 4);
    send_bits({22'd0, 5'd1, 5'd4}, 10);
    send_bits(32'h0003_FFFF, 18);
    repeat (10) @(posedge clk);
    chk("bad op no drive", 32'(oe_cyc - o0), 32'd0);
    chk("bad op no write", 32'(wr_cyc - w0), 32'd0);
    do_frame(1'b1, 5'd1, 5'd2, 16'h0000, 1'b0, rdata, ta2s);
    chk("after abort rdata", 32'(rdata), 32'h0022);

    // Reset while presenting data: pad released at once.
    send_hdr(1'b1, 5'd1, 5'd2);
    mdc_bit(1'b1, s);
    mdc_bit(1'b1, s);
    for (int i = 0; i < 7; i++) mdc_bit(1'b1, s);
    drv = 1'b1;
    #(HALF / 2);
    chk("oe before rst", 32'(mdio_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("oe after rst", 32'(mdio_oe), 32'd0);
    @(posedge clk);
    #1;
    chk("oe 1 clk after rst", 32'(mdio_oe), 32'd0);
    #(HALF / 2);
    mdc = 1'b1;
    #HALF;
    mdc = 1'b0;
    #1 rst = 1'b0;
    link_up = 1'b1;
    repeat (5) @(posedge clk);
    w0 = wr_cyc;
    do_frame(1'b1, 5'd1, 5'd1, 16'h0000, 1'b0, rdata, ta2s);
    chk("post-rst bmsr link", 32'(rdata), 32'h784D);
    chk("post-rst no write", 32'(wr_cyc - w0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
